// File: rtl/mem_requester.sv
// mem_requester: initiator-side front end for the memory controller.
// Client commands are tagged by address in a small outstanding-request
// table, issued as one-cycle wr_en/rd_en pulses, and retired either by a
// matching wr_ret/rd_ret acknowledgement (producing a client response) or
// by the age timeout (producing a sticky error instead).
module mem_requester #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_write_i,
   input  logic [15:0] cmd_addr_i,
   input  logic [15:0] cmd_data_i,
   output logic [15:0] wr_address_o,
   output logic        wr_en_o,
   output logic [15:0] wr_data_o,
   input  logic [15:0] wr_ret_address_i,
   input  logic        wr_ret_ack_i,
   output logic [15:0] rd_address_o,
   output logic        rd_en_o,
   input  logic [15:0] rd_ret_data_i,
   input  logic [15:0] rd_ret_address_i,
   input  logic        rd_ret_ack_i,
   output logic        rd_resp_valid_o,
   output logic [15:0] rd_resp_addr_o,
   output logic [15:0] rd_resp_data_o,
   output logic        wr_resp_valid_o,
   output logic [15:0] wr_resp_addr_o,
   output logic [4:0]  outstanding_o,
   output logic        err_unmatched_o,
   output logic        err_timeout_o
);

   localparam int IDX_W = $clog2(DEPTH);
   // With the timeout disabled the age counter is unused but kept one bit wide.
   localparam int AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // An entry is retired on the edge where its age would reach TIMEOUT,
   // so it stays outstanding for exactly TIMEOUT cycles.
   localparam logic [AGE_W-1:0] AGE_LAST = (TIMEOUT > 0) ? AGE_W'(TIMEOUT - 1) : '0;
   localparam logic [AGE_W-1:0] AGE_MAX  = (TIMEOUT > 0) ? AGE_W'(TIMEOUT) : '1;

   // Outstanding-request table
   logic [DEPTH-1:0]             valid_q, valid_d;
   logic [DEPTH-1:0]             is_wr_q, is_wr_d;
   logic [DEPTH-1:0][15:0]       addr_q, addr_d;
   logic [DEPTH-1:0][AGE_W-1:0]  age_q, age_d;

   // Controller-side issue registers
   logic        wr_en_q, rd_en_q;
   logic [15:0] wr_addr_q, wr_data_q, rd_addr_q;

   // Client-side response registers
   logic        rd_resp_valid_q, wr_resp_valid_q;
   logic [15:0] rd_resp_addr_q, rd_resp_data_q, wr_resp_addr_q;

   // Status
   logic [4:0]  outstanding_q, outstanding_d;
   logic        err_unmatched_q, err_timeout_q;

   // Per-cycle decode
   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic             addr_hit;
   logic             accept;
   logic [DEPTH-1:0] rd_hit_vec, wr_hit_vec, expire_vec, freed_vec;
   logic             rd_match, wr_match, any_expire;
   logic [4:0]       freed_cnt;

   // Lowest-index free slot; scanning downward lets the lowest index win.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // Address-as-tag lookups for the incoming command and both ack channels.
   always_comb begin
      addr_hit   = 1'b0;
      rd_hit_vec = '0;
      wr_hit_vec = '0;
      expire_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i] == cmd_addr_i))
            addr_hit = 1'b1;
         rd_hit_vec[i] = rd_ret_ack_i && valid_q[i] && !is_wr_q[i] &&
                         (addr_q[i] == rd_ret_address_i);
         wr_hit_vec[i] = wr_ret_ack_i && valid_q[i] && is_wr_q[i] &&
                         (addr_q[i] == wr_ret_address_i);
         // An ack landing on the expiry edge completes the entry normally.
         expire_vec[i] = (TIMEOUT > 0) && valid_q[i] && (age_q[i] == AGE_LAST) &&
                         !rd_hit_vec[i] && !wr_hit_vec[i];
      end
   end

   assign rd_match   = |rd_hit_vec;
   assign wr_match   = |wr_hit_vec;
   assign any_expire = |expire_vec;
   assign freed_vec  = rd_hit_vec | wr_hit_vec | expire_vec;

   // cmd_ready looks only at registered table state, so a slot or tag freed
   // by an ack this cycle becomes usable on the following cycle.
   assign cmd_ready_o = !reset_i && free_found && !addr_hit;
   assign accept      = cmd_valid_i && cmd_ready_o;

   // Number of entries retired this cycle (two acks plus any expiries).
   always_comb begin
      freed_cnt = '0;
      for (int i = 0; i < DEPTH; i++)
         freed_cnt = freed_cnt + {4'b0, freed_vec[i]};
   end

   assign outstanding_d = outstanding_q + {4'b0, accept} - freed_cnt;

   // Next table state: age, retire, then allocate into a slot that was free.
   always_comb begin
      valid_d = valid_q & ~freed_vec;
      is_wr_d = is_wr_q;
      addr_d  = addr_q;
      age_d   = age_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (age_q[i] != AGE_MAX))
            age_d[i] = age_q[i] + AGE_W'(1);
      end
      if (accept) begin
         valid_d[free_idx] = 1'b1;
         is_wr_d[free_idx] = cmd_write_i;
         addr_d[free_idx]  = cmd_addr_i;
         age_d[free_idx]   = '0;
      end
   end

   // Table registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q <= '0;
         is_wr_q <= '0;
         addr_q  <= '0;
         age_q   <= '0;
      end else begin
         valid_q <= valid_d;
         is_wr_q <= is_wr_d;
         addr_q  <= addr_d;
         age_q   <= age_d;
      end
   end

   // One-cycle request pulse the cycle after accept; address/data hold otherwise.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
      end else begin
         wr_en_q <= accept && cmd_write_i;
         rd_en_q <= accept && !cmd_write_i;
         if (accept && cmd_write_i) begin
            wr_addr_q <= cmd_addr_i;
            wr_data_q <= cmd_data_i;
         end
         if (accept && !cmd_write_i)
            rd_addr_q <= cmd_addr_i;
      end
   end

   // Completion pulses to the client for matched acks only.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_resp_valid_q <= 1'b0;
         rd_resp_addr_q  <= '0;
         rd_resp_data_q  <= '0;
         wr_resp_valid_q <= 1'b0;
         wr_resp_addr_q  <= '0;
      end else begin
         rd_resp_valid_q <= rd_match;
         wr_resp_valid_q <= wr_match;
         if (rd_match) begin
            rd_resp_addr_q <= rd_ret_address_i;
            rd_resp_data_q <= rd_ret_data_i;
         end
         if (wr_match)
            wr_resp_addr_q <= wr_ret_address_i;
      end
   end

   // Outstanding count and sticky error flags.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         outstanding_q   <= '0;
         err_unmatched_q <= 1'b0;
         err_timeout_q   <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         if ((rd_ret_ack_i && !rd_match) || (wr_ret_ack_i && !wr_match))
            err_unmatched_q <= 1'b1;
         if (any_expire)
            err_timeout_q <= 1'b1;
      end
   end

   assign wr_en_o         = wr_en_q;
   assign wr_address_o    = wr_addr_q;
   assign wr_data_o       = wr_data_q;
   assign rd_en_o         = rd_en_q;
   assign rd_address_o    = rd_addr_q;
   assign rd_resp_valid_o = rd_resp_valid_q;
   assign rd_resp_addr_o  = rd_resp_addr_q;
   assign rd_resp_data_o  = rd_resp_data_q;
   assign wr_resp_valid_o = wr_resp_valid_q;
   assign wr_resp_addr_o  = wr_resp_addr_q;
   assign outstanding_o   = outstanding_q;
   assign err_unmatched_o = err_unmatched_q;
   assign err_timeout_o   = err_timeout_q;

endmodule

// File: doc/mem_requester.md
Name: mem_requester

Overview:
- Initiator-side front end for the VPI-backed memory controller.
- Accepts read/write commands from a client over a valid/ready channel and issues them as single-cycle request pulses on the controller's wr_*/rd_* ports.
- Tracks outstanding requests in a tag table keyed by address, matches rd_ret/wr_ret acknowledgements back to their entries, and presents completions to the client.
- Flags unmatched acks and timed-out requests.

Parameters:
- DEPTH, 4, number of outstanding-request table entries (2..16).
- TIMEOUT, 1024, cycles an entry may stay outstanding before being retired with an error; 0 disables the timeout.

Ports:
- clk  input  1  clock, all logic on posedge
- reset  input  1  synchronous active-high reset
- cmd_valid  input  1  client command present
- cmd_ready  output  1  command accepted this cycle when high with cmd_valid
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  16  command address (also the tag)
- cmd_data  input  16  write data (ignored for reads)
- wr_address  output  16  to controller
- wr_en  output  1  to controller, one-cycle pulse
- wr_data  output  16  to controller
- wr_ret_address  input  16  from controller, completed write tag
- wr_ret_ack  input  1  from controller, write completion
- rd_address  output  16  to controller
- rd_en  output  1  to controller, one-cycle pulse
- rd_ret_data  input  16  from controller
- rd_ret_address  input  16  from controller, completed read tag
- rd_ret_ack  input  1  from controller, read completion
- rd_resp_valid  output  1  read completion pulse to client
- rd_resp_addr  output  16  completed read address
- rd_resp_data  output  16  read data
- wr_resp_valid  output  1  write completion pulse to client
- wr_resp_addr  output  16  completed write address
- outstanding  output  5  count of valid table entries
- err_unmatched  output  1  sticky: ack with no matching entry
- err_timeout  output  1  sticky: an entry exceeded TIMEOUT

Behaviour:
- Reset: all outputs 0, all table entries invalid, ages 0. Reset asserted mid-operation drops every outstanding entry. Acks arriving after reset are unmatched and set err_unmatched.
- Table entry fields: valid, is_write, addr[15:0], age.
  - age is $clog2(TIMEOUT+1) bits wide and saturates.
- cmd_ready (combinational from registered state) = !reset && free entry exists && no valid entry has addr == cmd_addr. Same-address requests are serialized because address is the tag.
- Accept (cmd_valid && cmd_ready at posedge):
  - Allocate the lowest-index free entry and set its age to 0.
  - Next cycle: for a write, wr_en=1 with wr_address/wr_data; for a read, rd_en=1 with rd_address. The pulse lasts exactly one cycle.
  - Address/data outputs hold their last values while en=0.
  - Max one issue per cycle; back-to-back accepts give back-to-back pulses.
- Return handling: rd_ret_ack and wr_ret_ack are sampled at posedge independently; both may be high in the same cycle.
  - An ack matches the valid entry with equal addr and matching is_write. A match frees the entry.
  - Next cycle, pulse the corresponding *_resp_valid with the address (and rd_ret_data for reads).
  - A read and a write completion in the same cycle produce both resp pulses in the same cycle.
- Unmatched ack (no entry, or type mismatch): no response pulse, no table change, err_unmatched set until reset.
- Same-cycle free and allocate:
  - A slot freed at edge N is allocatable from edge N+1 (cmd_ready reflects state, not incoming acks).
  - A cmd to an address whose ack arrives in the same cycle is stalled one cycle.
- Timeout (TIMEOUT>0):
  - Each valid entry's age increments per cycle.
  - When age reaches TIMEOUT, the entry is freed, err_timeout is set (sticky), and no response is produced.
  - A later ack for that address counts as unmatched.
  - An ack arriving in the same cycle age reaches TIMEOUT wins: normal completion, no error.
- outstanding is a registered count, updated on the same edge as the table: +1 for an allocate, -1 for each free (up to two acks plus any timeouts).

Test Plan:
- Write then read: cmd write 0x0010/0xBEEF accepted → wr_en pulse next cycle with 0x0010/0xBEEF; ack wr_ret 0x0010 → wr_resp_valid, addr 0x0010, outstanding 1→0. Then read 0x0010; rd_ret 0x0010/0xBEEF → rd_resp_data 0xBEEF.
- Full/out-of-order: issue DEPTH=4 reads to 0x1,0x2,0x3,0x4 → cmd_ready=0 at outstanding 4. Ack 0x3 then 0x1 → responses in ack order, cmd_ready high the cycle after the first ack.
- Address conflict: read 0x20 outstanding, cmd write 0x20 → cmd_ready=0 until the cycle after rd_ret 0x20; write to 0x21 is accepted meanwhile.
- Simultaneous returns: outstanding read 0x5 and write 0x6, both acks in the same cycle → rd_resp_valid and wr_resp_valid pulse together, outstanding 2→0.
- Errors: wr_ret_ack 0x99 with no entry → err_unmatched=1, no resp. With TIMEOUT=8, a read left unacked → freed after 8 cycles, err_timeout=1. A late ack then sets err_unmatched.
- Reset mid-flight: 3 entries outstanding, pulse reset → outstanding=0, cmd_ready=1, errors cleared. An old ack afterward → err_unmatched=1.
